// File: rtl/openadc_capture_seq.sv
// Capture sequencer in the ADC sample-clock domain: pre-trigger, offset, decimated capture, multi-segment.
// Optional trigger pulse-width measurement is built when CAPTURE_TRIG_LEN_EN is defined.
module openadc_capture_seq #(
  parameter int pNUM_TRIG  = 4,
  parameter int pSAMPLES_W = 32,
  parameter int pPRESAMP_W = 15,
  parameter int pSEG_W     = 16
) (
  input  logic                  adc_sampleclk,
  input  logic                  reset,
  input  logic                  arm_i,
  input  logic [pNUM_TRIG-1:0]  trig_i,
  input  logic [pNUM_TRIG-1:0]  trig_mask,
  input  logic                  trigger_mode,
  input  logic                  trigger_now,
  input  logic [31:0]           trigger_offset,
  input  logic [pPRESAMP_W-1:0] presamples,
  input  logic [pSAMPLES_W-1:0] maxsamples,
  input  logic [12:0]           downsample,
  input  logic [pSEG_W-1:0]     num_segments,
  input  logic [19:0]           segment_cycles,
  input  logic                  segment_mode,
  input  logic                  fifo_full,
  output logic                  sample_we,
  output logic                  armed,
  output logic                  capturing,
  output logic                  done,
  output logic                  overflow,
  output logic [pSEG_W-1:0]     segment_count,
  output logic [31:0]           trigger_length
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESAMP   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_OFFSET    = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_SEG_WAIT  = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [31:0]           CNT32_MAX = 32'hFFFF_FFFF;
  localparam logic [pSAMPLES_W-1:0] SAMP_MAX  = {pSAMPLES_W{1'b1}};
  localparam logic [pSAMPLES_W-1:0] SAMP_ZERO = {pSAMPLES_W{1'b0}};
  localparam logic [pSAMPLES_W-1:0] SAMP_ONE  = {{(pSAMPLES_W-1){1'b0}}, 1'b1};
  localparam logic [pPRESAMP_W-1:0] PRE_MAX   = {pPRESAMP_W{1'b1}};
  localparam logic [pPRESAMP_W-1:0] PRE_ONE   = {{(pPRESAMP_W-1){1'b0}}, 1'b1};
  localparam logic [pSEG_W-1:0]     SEG_MAX   = {pSEG_W{1'b1}};
  localparam logic [pSEG_W-1:0]     SEG_ZERO  = {pSEG_W{1'b0}};
  localparam logic [pSEG_W-1:0]     SEG_ONE   = {{(pSEG_W-1){1'b0}}, 1'b1};

  state_t                  state_r, state_nxt_s;
  logic [pNUM_TRIG-1:0]    trig_s1_r, trig_s2_r;
  logic                    trig_hist_r, arm_hist_r;
  logic                    trig_lvl_s, trig_edge_s, trig_fire_s, arm_rise_s;
  logic [12:0]             dec_cnt_r;
  logic [pPRESAMP_W-1:0]   pre_cnt_r;
  logic [pSAMPLES_W-1:0]   post_cnt_r, post_tgt_s, presamp_ext_s;
  logic [31:0]             off_cnt_r, seg_tmr_r;
  logic [pSEG_W-1:0]       seg_cnt_r, nseg_s;
  logic                    we_slot_s, ovf_s, seg_end_s, cap_last_s, seg_last_s;
  logic                    off_elapsed_s, seg_elapsed_s;
  logic                    enter_pre_s, enter_cap_s, enter_off_s, write_state_s;
  logic                    armed_r, capturing_r, done_r, overflow_r;

  // Trigger pin synchroniser, level history and arm edge history
  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      trig_s1_r   <= {pNUM_TRIG{1'b0}};
      trig_s2_r   <= {pNUM_TRIG{1'b0}};
      trig_hist_r <= 1'b0;
      arm_hist_r  <= 1'b0;
    end else begin
      trig_s1_r   <= trig_i;
      trig_s2_r   <= trig_s1_r;
      trig_hist_r <= trig_lvl_s;
      arm_hist_r  <= arm_i;
    end
  end

  assign trig_lvl_s  = |(trig_s2_r & trig_mask);
  assign trig_edge_s = trigger_mode ? (trig_lvl_s & ~trig_hist_r) : (~trig_lvl_s & trig_hist_r);
  assign trig_fire_s = trig_edge_s | trigger_now;
  assign arm_rise_s  = arm_i & ~arm_hist_r;

  assign presamp_ext_s = pSAMPLES_W'(presamples);
  assign post_tgt_s    = (maxsamples > presamp_ext_s) ? (maxsamples - presamp_ext_s) : SAMP_ZERO;
  assign nseg_s        = (num_segments == SEG_ZERO) ? SEG_ONE : num_segments;
  assign off_elapsed_s = ({1'b0, off_cnt_r} + 33'd1) >= {1'b0, trigger_offset};
  assign seg_elapsed_s = ({1'b0, seg_tmr_r} + 33'd1) >= {13'd0, segment_cycles};

  assign write_state_s = (state_r == ST_PRESAMP) || (state_r == ST_WAIT_TRIG) || (state_r == ST_CAPTURE);
  assign we_slot_s = (dec_cnt_r == 13'd0) &&
                     ((state_r == ST_PRESAMP) || (state_r == ST_WAIT_TRIG) ||
                      ((state_r == ST_CAPTURE) && (post_cnt_r < post_tgt_s)));
  // Write strobe is qualified by the current FIFO status so a full FIFO never sees a write
  assign sample_we  = we_slot_s & ~fifo_full;
  assign ovf_s      = we_slot_s & fifo_full;
  assign cap_last_s = (post_cnt_r >= post_tgt_s) || (sample_we && (post_cnt_r >= post_tgt_s - SAMP_ONE));
  assign seg_last_s = seg_cnt_r >= nseg_s - SEG_ONE;

  // Sequencer next-state decode
  always_comb begin
    state_nxt_s = state_r;
    seg_end_s   = 1'b0;
    if (!arm_i && (state_r != ST_DONE)) begin
      state_nxt_s = ST_IDLE;
    end else if (ovf_s) begin
      state_nxt_s = ST_DONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm_rise_s) state_nxt_s = ST_PRESAMP;
          else            state_nxt_s = ST_IDLE;
        end
        ST_PRESAMP: begin
          if (pre_cnt_r >= presamples) state_nxt_s = ST_WAIT_TRIG;
          else                         state_nxt_s = ST_PRESAMP;
        end
        ST_WAIT_TRIG: begin
          if (!trig_fire_s)                 state_nxt_s = ST_WAIT_TRIG;
          else if (trigger_offset == 32'd0) state_nxt_s = ST_CAPTURE;
          else                              state_nxt_s = ST_OFFSET;
        end
        ST_OFFSET: begin
          if (off_elapsed_s) state_nxt_s = ST_CAPTURE;
          else               state_nxt_s = ST_OFFSET;
        end
        ST_CAPTURE: begin
          if (cap_last_s) begin
            seg_end_s = 1'b1;
            if (seg_last_s)         state_nxt_s = ST_DONE;
            else if (!segment_mode) state_nxt_s = ST_WAIT_TRIG;
            else if (seg_elapsed_s) state_nxt_s = ST_CAPTURE;
            else                    state_nxt_s = ST_SEG_WAIT;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        ST_SEG_WAIT: begin
          if (seg_elapsed_s) state_nxt_s = ST_CAPTURE;
          else               state_nxt_s = ST_SEG_WAIT;
        end
        ST_DONE: begin
          if (!arm_i) state_nxt_s = ST_IDLE;
          else        state_nxt_s = ST_DONE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  assign enter_pre_s = (state_nxt_s == ST_PRESAMP) && (state_r != ST_PRESAMP);
  assign enter_off_s = (state_nxt_s == ST_OFFSET) && (state_r != ST_OFFSET);
  assign enter_cap_s = (state_nxt_s == ST_CAPTURE) && ((state_r != ST_CAPTURE) || seg_end_s);

  // State register, saturating counters and registered status outputs
  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      dec_cnt_r   <= 13'd0;
      pre_cnt_r   <= {pPRESAMP_W{1'b0}};
      post_cnt_r  <= SAMP_ZERO;
      off_cnt_r   <= 32'd0;
      seg_tmr_r   <= 32'd0;
      seg_cnt_r   <= SEG_ZERO;
      armed_r     <= 1'b0;
      capturing_r <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (enter_pre_s || enter_cap_s)  dec_cnt_r <= 13'd0;
      else if (write_state_s)          dec_cnt_r <= (dec_cnt_r >= downsample) ? 13'd0 : dec_cnt_r + 13'd1;
      else                             dec_cnt_r <= dec_cnt_r;
      if (enter_pre_s)                                                        pre_cnt_r <= {pPRESAMP_W{1'b0}};
      else if ((state_r == ST_PRESAMP) && sample_we && (pre_cnt_r != PRE_MAX)) pre_cnt_r <= pre_cnt_r + PRE_ONE;
      else                                                                    pre_cnt_r <= pre_cnt_r;
      if (enter_cap_s)                                                          post_cnt_r <= SAMP_ZERO;
      else if ((state_r == ST_CAPTURE) && sample_we && (post_cnt_r != SAMP_MAX)) post_cnt_r <= post_cnt_r + SAMP_ONE;
      else                                                                      post_cnt_r <= post_cnt_r;
      if (enter_off_s)                                            off_cnt_r <= 32'd0;
      else if ((state_r == ST_OFFSET) && (off_cnt_r != CNT32_MAX)) off_cnt_r <= off_cnt_r + 32'd1;
      else                                                        off_cnt_r <= off_cnt_r;
      // Segment spacing is measured from the first capture clock of the previous segment
      if (enter_cap_s)                   seg_tmr_r <= 32'd0;
      else if (seg_tmr_r != CNT32_MAX)   seg_tmr_r <= seg_tmr_r + 32'd1;
      else                               seg_tmr_r <= seg_tmr_r;
      if (enter_pre_s)                             seg_cnt_r <= SEG_ZERO;
      else if (seg_end_s && (seg_cnt_r != SEG_MAX)) seg_cnt_r <= seg_cnt_r + SEG_ONE;
      else                                         seg_cnt_r <= seg_cnt_r;
      if (enter_pre_s)                   done_r <= 1'b0;
      else if (state_nxt_s == ST_DONE)   done_r <= 1'b1;
      else                               done_r <= done_r;
      if (enter_pre_s)  overflow_r <= 1'b0;
      else if (ovf_s)   overflow_r <= 1'b1;
      else              overflow_r <= overflow_r;
      armed_r     <= (state_nxt_s == ST_PRESAMP) || (state_nxt_s == ST_WAIT_TRIG);
      capturing_r <= (state_nxt_s == ST_OFFSET) || (state_nxt_s == ST_CAPTURE) ||
                     (state_nxt_s == ST_SEG_WAIT);
    end
  end

  assign armed         = armed_r;
  assign capturing     = capturing_r;
  assign done          = done_r;
  assign overflow      = overflow_r;
  assign segment_count = seg_cnt_r;

`ifdef CAPTURE_TRIG_LEN_EN
  logic        trig_act_s, trig_act_hist_s;
  logic [31:0] trig_len_cnt_r, trig_len_r;

  assign trig_act_s      = trigger_mode ? trig_lvl_s  : ~trig_lvl_s;
  assign trig_act_hist_s = trigger_mode ? trig_hist_r : ~trig_hist_r;

  // Active-time counter of the masked trigger; length latched when the pulse ends
  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      trig_len_cnt_r <= 32'd0;
      trig_len_r     <= 32'd0;
    end else begin
      if (trig_act_s && !trig_act_hist_s)          trig_len_cnt_r <= 32'd1;
      else if (trig_act_s && (trig_len_cnt_r != CNT32_MAX)) trig_len_cnt_r <= trig_len_cnt_r + 32'd1;
      else                                         trig_len_cnt_r <= trig_len_cnt_r;
      if (!trig_act_s && trig_act_hist_s) trig_len_r <= trig_len_cnt_r;
      else                                trig_len_r <= trig_len_r;
    end
  end

  assign trigger_length = trig_len_r;
`else
  assign trigger_length = 32'h0;
`endif

endmodule
